// File: rtl/glitch_sequencer.sv
// glitch_sequencer: table-driven multi-pulse power-glitch generator.
// Offsets/durations are programmed while idle; one pulse train is emitted per arm + trigger.
module glitch_sequencer #(
    parameter int WIDTH       = 32,
    parameter int NUM_PULSES  = 4,
    parameter int IDX_W       = 2,
    parameter int ACTIVE_HIGH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic [IDX_W:0]   pulse_count,
    input  logic             arm,
    input  logic             trigger,
    input  logic             abort,
    output logic             power_ctrl,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] pulse_idx
);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [2:0] {IDLE, ARMED, OFFSET, GLITCH, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             active_q, active_d;

    logic [WIDTH-1:0] off_tbl [NUM_PULSES];
    logic [WIDTH-1:0] dur_tbl [NUM_PULSES];

    logic             cfg_ok;
    logic             advance;
    logic             more;
    logic [IDX_W-1:0] nxt_idx;
    logic [WIDTH-1:0] nxt_off, nxt_dur;
    logic [CNT_W-1:0] sat_count;

    assign busy       = (state_q == ARMED) || (state_q == OFFSET) || (state_q == GLITCH);
    assign done       = (state_q == DONE);
    assign pulse_idx  = idx_q;
    assign power_ctrl = (ACTIVE_HIGH != 0) ? active_q : ~active_q;

    assign cfg_ok    = cfg_we && !busy && (32'(cfg_addr) < 32'(NUM_PULSES));
    assign sat_count = (32'(pulse_count) > 32'(NUM_PULSES)) ? CNT_W'(NUM_PULSES) : pulse_count;
    assign more      = (CNT_W'(idx_q) + CNT_W'(1)) < count_q;
    assign nxt_idx   = idx_q + IDX_W'(1);
    assign nxt_off   = off_tbl[nxt_idx];
    assign nxt_dur   = dur_tbl[nxt_idx];

    // NOTE: the table is small and must read back as zero after reset, so it lives in
    // flops with an async clear rather than in an inferred RAM that cannot be reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PULSES; i++) begin
                off_tbl[i] <= '0;
                dur_tbl[i] <= '0;
            end
        end else if (cfg_ok) begin
            if (cfg_sel) dur_tbl[cfg_addr] <= cfg_data;
            else         off_tbl[cfg_addr] <= cfg_data;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        idx_d     = idx_q;
        count_d   = count_q;
        active_d  = active_q;
        advance   = 1'b0;

        if (abort && busy) begin
            state_d   = IDLE;
            counter_d = '0;
            idx_d     = '0;
            active_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (arm) begin
                    state_d = ARMED;
                    count_d = sat_count;
                end
                ARMED: if (trigger) begin
                    if (count_q == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d   = OFFSET;
                        counter_d = off_tbl[0];
                        idx_d     = '0;
                    end
                end
                OFFSET: begin
                    if (counter_q != '0) begin
                        counter_d = counter_q - WIDTH'(1);
                    end else if (dur_tbl[idx_q] != '0) begin
                        state_d   = GLITCH;
                        counter_d = dur_tbl[idx_q];
                        active_d  = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
                GLITCH: begin
                    if (counter_q > WIDTH'(1)) counter_d = counter_q - WIDTH'(1);
                    else                       advance   = 1'b1;
                end
                DONE: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
                default: state_d = IDLE;
            endcase

            // End of a pulse or a skipped entry: the next rise lands nxt_off edges later,
            // so a zero offset with a non-zero duration continues the pulse without a gap.
            if (advance) begin
                if (more) begin
                    idx_d = nxt_idx;
                    if (nxt_off == '0 && nxt_dur != '0) begin
                        state_d   = GLITCH;
                        counter_d = nxt_dur;
                        active_d  = 1'b1;
                    end else begin
                        state_d   = OFFSET;
                        counter_d = (nxt_off == '0) ? '0 : nxt_off - WIDTH'(1);
                        active_d  = 1'b0;
                    end
                end else begin
                    state_d  = DONE;
                    active_d = 1'b0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values and the evaluation order of processes cannot matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            counter_q <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            active_q  <= active_d;
        end
    end
endmodule

// File: tb/tb_glitch_sequencer.sv
// Bench for glitch_sequencer: a 32-bit active-high build and a 4-bit inverted build share stimulus;
// expected waveforms come from a timestamp model of the pulse table.
module tb_glitch_sequencer;
    localparam int NUM  = 4;
    localparam int MAXC = 256;

    logic        clk = 1'b0;
    logic        rst_n, rst_n_b;
    logic        cfg_we, cfg_sel;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic [2:0]  pulse_count;
    logic        arm, trigger, abort;
    logic        pc_a, busy_a, done_a;
    logic [1:0]  idx_a;
    logic        pc_b, busy_b, done_b;
    logic [1:0]  idx_b;

    int vectors     = 0;
    int miscompares = 0;
    bit b_live      = 1'b1;

    int m_off [NUM];
    int m_dur [NUM];
    int exp_len, exp_end;
    bit exp_pc   [MAXC];
    bit exp_done [MAXC];
    bit exp_busy [MAXC];
    int exp_idx  [MAXC];

    always #5 clk = ~clk;

    glitch_sequencer #(.WIDTH(32), .NUM_PULSES(4), .IDX_W(2), .ACTIVE_HIGH(1)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .pulse_count(pulse_count), .arm(arm), .trigger(trigger),
        .abort(abort), .power_ctrl(pc_a), .busy(busy_a), .done(done_a), .pulse_idx(idx_a)
    );

    glitch_sequencer #(.WIDTH(4), .NUM_PULSES(4), .IDX_W(2), .ACTIVE_HIGH(0)) dut_n (
        .clk(clk), .rst_n(rst_n_b), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data[3:0]), .pulse_count(pulse_count), .arm(arm), .trigger(trigger),
        .abort(abort), .power_ctrl(pc_b), .busy(busy_b), .done(done_b), .pulse_idx(idx_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input bit sel, input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = 2'(addr);
        cfg_data = 32'(data);
        tick();
        cfg_we = 1'b0;
        if (sel) m_dur[addr] = data;
        else     m_off[addr] = data;
    endtask

    // Each pulse k is a window [rise, fall) in cycles after the trigger edge E. Pulse 0 rises
    // offset[0]+1 after E; later entries start offset[k] after the previous fall (or skip point),
    // and a skipped zero-offset entry still occupies one cycle. done fills the cycle after the last.
    task automatic build_expect(input int req);
        int n;
        int d [NUM];
        int e [NUM];
        int st[NUM];
        n = (req > NUM) ? NUM : req;
        exp_end = 0;
        for (int k = 0; k < n; k++) begin
            if (k == 0) begin
                st[k] = 0;
                d[k]  = m_off[0] + 1;
            end else begin
                st[k] = e[k-1];
                d[k]  = e[k-1] + ((m_off[k] == 0 && m_dur[k] == 0) ? 1 : m_off[k]);
            end
            e[k]    = d[k] + m_dur[k];
            exp_end = e[k];
        end
        exp_len = (exp_end + 4 > MAXC) ? MAXC : exp_end + 4;
        for (int c = 0; c < exp_len; c++) begin
            exp_pc[c]   = 1'b0;
            exp_idx[c]  = 0;
            exp_done[c] = (c == exp_end);
            exp_busy[c] = (c < exp_end);
            for (int k = 0; k < n; k++) begin
                if (c >= d[k] && c < d[k] + m_dur[k]) exp_pc[c] = 1'b1;
                if (c >= st[k]) exp_idx[c] = k;
            end
        end
    endtask

    task automatic run_seq(input string name, input int req, input bit hold, input bit poke);
        build_expect(req);
        pulse_count = 3'(req);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL %s armed_busy got %b want 1", name, busy_a);
        end
        trigger = 1'b1;
        tick();
        if (!hold) trigger = 1'b0;
        for (int c = 0; c < exp_len; c++) begin
            if (poke && c == 1) begin
                cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 2'd0; cfg_data = 32'd7;
            end
            arm = hold && (c < exp_end);
            @(negedge clk);
            vectors++;
            if (pc_a !== exp_pc[c]) begin
                miscompares++;
                $display("FAIL %s cycle %0d power_ctrl got %b want %b", name, c, pc_a, exp_pc[c]);
            end
            vectors++;
            if (done_a !== exp_done[c]) begin
                miscompares++;
                $display("FAIL %s cycle %0d done got %b want %b", name, c, done_a, exp_done[c]);
            end
            vectors++;
            if (busy_a !== exp_busy[c]) begin
                miscompares++;
                $display("FAIL %s cycle %0d busy got %b want %b", name, c, busy_a, exp_busy[c]);
            end
            if (exp_busy[c]) begin
                vectors++;
                if (int'(idx_a) != exp_idx[c]) begin
                    miscompares++;
                    $display("FAIL %s cycle %0d pulse_idx got %0d want %0d", name, c, idx_a, exp_idx[c]);
                end
            end
            if (b_live) begin
                vectors++;
                if (pc_b !== ~exp_pc[c] || done_b !== exp_done[c] || busy_b !== exp_busy[c]
                    || (exp_busy[c] && int'(idx_b) != exp_idx[c])) begin
                    miscompares++;
                    $display("FAIL %s_inv cycle %0d pc/done/busy/idx got %b%b%b/%0d want %b%b%b/%0d",
                             name, c, pc_b, done_b, busy_b, idx_b,
                             ~exp_pc[c], exp_done[c], exp_busy[c], exp_idx[c]);
                end
            end
            tick();
            cfg_we = 1'b0;
        end
        arm     = 1'b0;
        trigger = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({pc_a, busy_a, done_a, idx_a} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_a pc/busy/done/idx got %b%b%b%b want 00000", pc_a, busy_a, done_a, idx_a);
        end
        vectors++;
        if ({pc_b, busy_b, done_b, idx_b} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_b pc/busy/done/idx got %b%b%b%b want 10000", pc_b, busy_b, done_b, idx_b);
        end
        rst_n   = 1'b1;
        rst_n_b = 1'b1;
        trigger = 1'b1;
        tick();
        tick();
        trigger = 1'b0;
        @(negedge clk);
        vectors++;
        if ({pc_a, busy_a, pc_b, busy_b} !== 4'b0010) begin
            miscompares++;
            $display("FAIL idle_trigger pc_a/busy_a/pc_b/busy_b got %b%b%b%b want 0010", pc_a, busy_a, pc_b, busy_b);
        end
        run_seq("cleared_table", 1, 1'b0, 1'b0);
    endtask

    task automatic test_single();
        write_cfg(1'b0, 0, 10);
        write_cfg(1'b1, 0, 5);
        run_seq("single", 1, 1'b0, 1'b0);
    endtask

    task automatic test_multi();
        write_cfg(1'b0, 0, 2); write_cfg(1'b1, 0, 4);
        write_cfg(1'b0, 1, 3); write_cfg(1'b1, 1, 1);
        write_cfg(1'b0, 2, 0); write_cfg(1'b1, 2, 2);
        run_seq("multi", 3, 1'b0, 1'b0);
    endtask

    task automatic test_skip();
        write_cfg(1'b0, 0, 2); write_cfg(1'b1, 0, 2);
        write_cfg(1'b0, 1, 3); write_cfg(1'b1, 1, 0);
        write_cfg(1'b0, 2, 1); write_cfg(1'b1, 2, 3);
        run_seq("skip", 3, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        write_cfg(1'b0, 0, 1);
        write_cfg(1'b1, 0, 10);
        pulse_count = 3'd1;
        arm = 1'b1; tick(); arm = 1'b0;
        trigger = 1'b1; tick(); trigger = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        @(negedge clk);
        vectors++;
        if (pc_a !== 1'b1 || pc_b !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_pre pc_a/pc_b got %b%b want 10", pc_a, pc_b);
        end
        tick();
        abort = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if ({pc_a, busy_a, done_a, pc_b, busy_b, done_b} !== 6'b000100) begin
                miscompares++;
                $display("FAIL abort_post cycle %0d a pc/busy/done %b%b%b b %b%b%b want 000 100",
                         c, pc_a, busy_a, done_a, pc_b, busy_b, done_b);
            end
            tick();
        end
        write_cfg(1'b0, 0, 3);
        run_seq("after_abort", 1, 1'b0, 1'b0);
    endtask

    task automatic test_busy_write();
        write_cfg(1'b0, 0, 4);
        write_cfg(1'b1, 0, 3);
        run_seq("busy_write", 1, 1'b0, 1'b1);
        run_seq("rerun", 1, 1'b0, 1'b0);
        run_seq("zero_count", 0, 1'b0, 1'b0);
    endtask

    task automatic test_held_inputs();
        write_cfg(1'b0, 1, 2);
        write_cfg(1'b1, 1, 2);
        run_seq("held_trigger_arm", 2, 1'b1, 1'b0);
    endtask

    task automatic test_max_offset();
        write_cfg(1'b0, 0, 15); write_cfg(1'b1, 0, 2);
        write_cfg(1'b0, 1, 15); write_cfg(1'b1, 1, 1);
        run_seq("max_offset", 2, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < NUM; k++) begin
                write_cfg(1'b0, k, int'($urandom_range(0, 5)));
                write_cfg(1'b1, k, int'($urandom_range(0, 4)));
            end
            run_seq("random", int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic test_async_reset();
        write_cfg(1'b0, 0, 2);
        write_cfg(1'b1, 0, 6);
        pulse_count = 3'd1;
        arm = 1'b1; tick(); arm = 1'b0;
        trigger = 1'b1; tick(); trigger = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        vectors++;
        if (pc_b !== 1'b0) begin
            miscompares++;
            $display("FAIL async_pre pc_b got %b want 0", pc_b);
        end
        #2 rst_n_b = 1'b0;
        #1;
        vectors++;
        if ({pc_b, busy_b, done_b, idx_b} !== 5'b10000) begin
            miscompares++;
            $display("FAIL async_reset pc/busy/done/idx got %b%b%b%b want 10000", pc_b, busy_b, done_b, idx_b);
        end
        b_live = 1'b0;
        abort  = 1'b1; tick(); abort = 1'b0;
        @(negedge clk);
        vectors++;
        if (pc_a !== 1'b0 || busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL async_abort_a pc/busy got %b%b want 00", pc_a, busy_a);
        end
    endtask

    initial begin
        rst_n = 1'b0; rst_n_b = 1'b0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
        pulse_count = '0; arm = 1'b0; trigger = 1'b0; abort = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            m_off[k] = 0;
            m_dur[k] = 0;
        end
        #12;
        test_reset();
        test_single();
        test_multi();
        test_skip();
        test_abort();
        test_busy_write();
        test_held_inputs();
        test_max_offset();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
